// File: rtl/cpu_btb_predictor_pkg.sv
// Shared definitions for the BTB predictor: counter arithmetic and address split helpers.
package cpu_btb_predictor_pkg;

  // Counters are computed at this width and truncated to CTR_WIDTH by the caller.
  localparam int CTR_MAX_W = 8;

  typedef logic [CTR_MAX_W-1:0] ctr_t;

  function automatic ctr_t ctr_next(input ctr_t ctr, input int w, input logic taken);
    ctr_t top;
    top = ctr_t'((1 << w) - 1);
    if (taken) return (ctr == top) ? ctr : ctr + ctr_t'(1);
    else       return (ctr == '0)  ? ctr : ctr - ctr_t'(1);
  endfunction

  function automatic ctr_t ctr_weak_taken(input int w);
    return ctr_t'(1 << (w - 1));
  endfunction

  function automatic ctr_t ctr_weak_not_taken(input int w);
    return ctr_t'((1 << (w - 1)) - 1);
  endfunction

  function automatic int tag_width(input int xlen, input int set_w);
    return xlen - set_w - 2;
  endfunction

  function automatic int hist_port_width(input int hist_w);
    return (hist_w > 0) ? hist_w : 1;
  endfunction

endpackage

// File: rtl/cpu_btb_predictor_if.sv
// Fetch-side lookup and commit-side training bus of the BTB predictor.
interface cpu_btb_predictor_if #(
  parameter int XLEN   = 32,
  parameter int HIST_W = 6
);
  logic [XLEN-1:0]   lookup_pc;
  logic              predict_hit;
  logic              predict_taken;
  logic [XLEN-1:0]   predict_target;
  logic [HIST_W-1:0] predict_hist;
  logic              update;
  logic [XLEN-1:0]   update_pc;
  logic              update_taken;
  logic [XLEN-1:0]   update_target;
  logic [HIST_W-1:0] update_hist;

  modport master (
    output lookup_pc, update, update_pc, update_taken, update_target, update_hist,
    input  predict_hit, predict_taken, predict_target, predict_hist
  );

  modport slave (
    input  lookup_pc, update, update_pc, update_taken, update_target, update_hist,
    output predict_hit, predict_taken, predict_target, predict_hist
  );
endinterface

// File: rtl/cpu_btb_set_victim.sv
// Per-set round-robin pointers and invalid-first victim selection for allocation.
module cpu_btb_set_victim #(
  parameter int SET_WIDTH = 6,
  parameter int WAYS      = 2,
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SET_WIDTH-1:0] set,
  input  logic [WAYS-1:0]      valid,
  input  logic                 alloc,
  output logic [WAY_W-1:0]     victim
);
  localparam int SETS = 1 << SET_WIDTH;

  logic [WAY_W-1:0] ptr [SETS];
  logic             found;

  always_comb begin
    victim = ptr[set];
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  // Pointer only advances when a live entry is actually evicted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) ptr[s] <= '0;
    end else if (alloc && (&valid) && (WAYS > 1)) begin
      ptr[set] <= ptr[set] + WAY_W'(1);
    end
  end
endmodule

// File: rtl/cpu_btb_predictor.sv
// N-way set-associative BTB with saturating direction counters and optional gshare indexing.
module cpu_btb_predictor
  import cpu_btb_predictor_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CTR_WIDTH  = 2,
  parameter int SET_WIDTH  = 6,
  parameter int WAYS       = 2,
  parameter int HIST_WIDTH = 6
) (
  input logic clk,
  input logic rst_n,
  cpu_btb_predictor_if.slave bus
);
  localparam int SETS  = 1 << SET_WIDTH;
  localparam int TAG_W = tag_width(XLEN, SET_WIDTH);
  localparam int HW    = hist_port_width(HIST_WIDTH);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [SETS-1:0][WAYS-1:0] valid;
  logic [TAG_W-1:0]          tag_mem [SETS][WAYS];
  logic [XLEN-1:0]           tgt_mem [SETS][WAYS];
  logic [CTR_WIDTH-1:0]      ctr_mem [SETS][WAYS];
  logic [HW-1:0]             ghr;

  function automatic logic [SET_WIDTH-1:0] set_of(input logic [XLEN-1:0] pc, input logic [HW-1:0] h);
    if (HIST_WIDTH > 0) return pc[SET_WIDTH+1:2] ^ SET_WIDTH'(h);
    else                return pc[SET_WIDTH+1:2];
  endfunction

  // Lookup path reads pre-edge state, so same-cycle updates are invisible.
  logic [SET_WIDTH-1:0] lset;
  logic [TAG_W-1:0]     ltag;
  logic                 lhit;
  logic [WAY_W-1:0]     lway;

  always_comb begin
    lset = set_of(bus.lookup_pc, ghr);
    ltag = bus.lookup_pc[XLEN-1:SET_WIDTH+2];
    lhit = 1'b0;
    lway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[lset][w] && tag_mem[lset][w] == ltag) begin
        lhit = 1'b1;
        lway = WAY_W'(w);
      end
    end
  end

  assign bus.predict_hit    = lhit;
  assign bus.predict_taken  = lhit && ctr_mem[lset][lway][CTR_WIDTH-1];
  assign bus.predict_target = lhit ? tgt_mem[lset][lway] : '0;
  assign bus.predict_hist   = ghr;

  logic [SET_WIDTH-1:0] uset;
  logic [TAG_W-1:0]     utag;
  logic                 uhit;
  logic [WAY_W-1:0]     uway;
  logic [WAY_W-1:0]     victim;
  logic                 alloc;

  always_comb begin
    uset = set_of(bus.update_pc, bus.update_hist);
    utag = bus.update_pc[XLEN-1:SET_WIDTH+2];
    uhit = 1'b0;
    uway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[uset][w] && tag_mem[uset][w] == utag) begin
        uhit = 1'b1;
        uway = WAY_W'(w);
      end
    end
  end

  assign alloc = bus.update && !uhit && bus.update_taken;

  cpu_btb_set_victim #(.SET_WIDTH(SET_WIDTH), .WAYS(WAYS)) u_victim (
    .clk    (clk),
    .rst_n  (rst_n),
    .set    (uset),
    .valid  (valid[uset]),
    .alloc  (alloc && rst_n),
    .victim (victim)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      ghr   <= '0;
    end else if (bus.update) begin
      if (uhit) begin
        ctr_mem[uset][uway] <= CTR_WIDTH'(ctr_next(ctr_t'(ctr_mem[uset][uway]), CTR_WIDTH, bus.update_taken));
        if (bus.update_taken) tgt_mem[uset][uway] <= bus.update_target;
      end else if (bus.update_taken) begin
        valid[uset][victim]   <= 1'b1;
        tag_mem[uset][victim] <= utag;
        tgt_mem[uset][victim] <= bus.update_target;
        ctr_mem[uset][victim] <= CTR_WIDTH'(ctr_weak_taken(CTR_WIDTH));
      end
      if (HIST_WIDTH > 0) ghr <= HW'({ghr, bus.update_taken});
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.lookup_pc[1:0], bus.update_pc[1:0], bus.update_hist};
endmodule

// File: tb/tb_cpu_btb_predictor.sv
// Directed bench: one non-gshare instance (HIST_WIDTH=0) and one gshare instance (HIST_WIDTH=6).
module tb_cpu_btb_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  cpu_btb_predictor_if #(.XLEN(32), .HIST_W(1)) b0 ();
  cpu_btb_predictor_if #(.XLEN(32), .HIST_W(6)) b1 ();

  cpu_btb_predictor #(.XLEN(32), .CTR_WIDTH(2), .SET_WIDTH(6), .WAYS(2), .HIST_WIDTH(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));
  cpu_btb_predictor #(.XLEN(32), .CTR_WIDTH(2), .SET_WIDTH(6), .WAYS(2), .HIST_WIDTH(6)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic u0_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    b0.update = 1'b1; b0.update_pc = pc; b0.update_taken = tk; b0.update_target = tg; b0.update_hist = '0;
    @(posedge clk); #1;
    b0.update = 1'b0;
  endtask

  task automatic u1_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic [5:0] h);
    b1.update = 1'b1; b1.update_pc = pc; b1.update_taken = tk; b1.update_target = tg; b1.update_hist = h;
    @(posedge clk); #1;
    b1.update = 1'b0;
  endtask

  task automatic l0(input logic [31:0] pc);
    b0.lookup_pc = pc; #1;
  endtask

  task automatic l1(input logic [31:0] pc);
    b1.lookup_pc = pc; #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    b0.lookup_pc = '0; b0.update = 1'b0; b0.update_pc = '0; b0.update_taken = 1'b0;
    b0.update_target = '0; b0.update_hist = '0;
    b1.lookup_pc = '0; b1.update = 1'b0; b1.update_pc = '0; b1.update_taken = 1'b0;
    b1.update_target = '0; b1.update_hist = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    l0(32'h100);
    chk("rst_hit", b0.predict_hit, 0);
    chk("rst_taken", b0.predict_taken, 0);
    chk("rst_target", b0.predict_target, 0);
    chk("rst_hist", b0.predict_hist, 0);
    chk("rst_hist_g", b1.predict_hist, 0);

    // First allocation; same-cycle lookup still misses
    b0.update = 1'b1; b0.update_pc = 32'h100; b0.update_taken = 1'b1; b0.update_target = 32'h200;
    b0.lookup_pc = 32'h100; #1;
    chk("same_cycle_hit", b0.predict_hit, 0);
    @(posedge clk); #1;
    b0.update = 1'b0;
    l0(32'h100);
    chk("alloc_hit", b0.predict_hit, 1);
    chk("alloc_taken", b0.predict_taken, 1);
    chk("alloc_target", b0.predict_target, 32'h200);

    // Counter walk: 10 -> 01 -> 00 -> 01 -> 10 -> 11 -> 11 -> 11 -> 10
    u0_upd(32'h100, 1'b0, 32'h0); l0(32'h100);
    chk("nt1_hit", b0.predict_hit, 1);
    chk("nt1_taken", b0.predict_taken, 0);
    u0_upd(32'h100, 1'b0, 32'h0); l0(32'h100);
    chk("nt2_hit", b0.predict_hit, 1);
    chk("nt2_taken", b0.predict_taken, 0);
    chk("nt2_target", b0.predict_target, 32'h200);
    u0_upd(32'h100, 1'b1, 32'h200); l0(32'h100);
    chk("t1_taken", b0.predict_taken, 0);
    u0_upd(32'h100, 1'b1, 32'h200); l0(32'h100);
    chk("t2_taken", b0.predict_taken, 1);
    u0_upd(32'h100, 1'b1, 32'h300); l0(32'h100);
    chk("t3_taken", b0.predict_taken, 1);
    chk("t3_target", b0.predict_target, 32'h300);
    u0_upd(32'h100, 1'b1, 32'h300); l0(32'h100);
    chk("t4_taken", b0.predict_taken, 1);
    u0_upd(32'h100, 1'b1, 32'h300); l0(32'h100);
    chk("t5_taken", b0.predict_taken, 1);
    u0_upd(32'h100, 1'b0, 32'h0); l0(32'h100);
    chk("sat_nt_taken", b0.predict_taken, 1);
    chk("sat_nt_target", b0.predict_target, 32'h300);

    // Eviction: three tags into set 0 of a 2-way table
    pulse_reset();
    u0_upd(32'h100, 1'b1, 32'h111);
    u0_upd(32'h500, 1'b1, 32'h555);
    u0_upd(32'h900, 1'b1, 32'h999);
    l0(32'h100);
    chk("evict_old_hit", b0.predict_hit, 0);
    chk("evict_old_target", b0.predict_target, 0);
    l0(32'h500);
    chk("evict_w1_hit", b0.predict_hit, 1);
    chk("evict_w1_target", b0.predict_target, 32'h555);
    l0(32'h900);
    chk("evict_new_hit", b0.predict_hit, 1);
    chk("evict_new_target", b0.predict_target, 32'h999);
    u0_upd(32'h100, 1'b0, 32'h777); l0(32'h100);
    chk("miss_nt_noalloc", b0.predict_hit, 0);
    l0(32'h500);
    chk("miss_nt_keep", b0.predict_hit, 1);

    // Gshare history and history-indexed lookup
    u1_upd(32'h1000, 1'b1, 32'h2222, 6'd0);
    chk("ghr_1", b1.predict_hist, 6'd1);
    u1_upd(32'h1000, 1'b0, 32'h0, 6'd0);
    chk("ghr_2", b1.predict_hist, 6'd2);
    u1_upd(32'h40, 1'b1, 32'h4444, 6'd5);
    chk("ghr_5", b1.predict_hist, 6'd5);
    l1(32'h40);
    chk("gs_hit", b1.predict_hit, 1);
    chk("gs_taken", b1.predict_taken, 1);
    chk("gs_target", b1.predict_target, 32'h4444);
    u1_upd(32'h2000, 1'b0, 32'h0, 6'd0);
    chk("ghr_a", b1.predict_hist, 6'h0a);
    l1(32'h40);
    chk("gs_shift_miss", b1.predict_hit, 0);

    // Reset wins over a simultaneous taken update
    rst_n = 1'b0;
    b0.update = 1'b1; b0.update_pc = 32'hc00; b0.update_taken = 1'b1; b0.update_target = 32'hccc;
    b1.update = 1'b1; b1.update_pc = 32'h40; b1.update_taken = 1'b1; b1.update_target = 32'h4040;
    b1.update_hist = 6'd0;
    @(posedge clk); #1;
    b0.update = 1'b0; b1.update = 1'b0; rst_n = 1'b1;
    l0(32'hc00);
    chk("rst_upd_hit", b0.predict_hit, 0);
    l1(32'h40);
    chk("rst_upd_hit_g", b1.predict_hit, 0);
    chk("rst_upd_ghr", b1.predict_hist, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
